ps_kernel_window: RTL and testbench

- Parametrised 3x3 neighbourhood generator.
- Stores a raster greyscale stream in four rotating line buffers and emits one 3x3 window per pixel to the convolution MAC.
- Generalises pixel width, line length and frame height, and adds a selectable border mode, bottom-row handling and downstream backpressure.
- Sits between the greyscale converter and the Gaussian/Sobel kernels.

---
 rtl/ps_kernel_window.sv | 177 +++++++++++++++++
 tb/tb_ps_kernel_window.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_kernel_window.sv
// 3x3 neighbourhood generator: four rotating line buffers feed one window per pixel downstream.
// Optional status outputs o_sof/o_eol are compiled in when PS_KWIN_STATUS_EN is defined.
module ps_kernel_window #(
   parameter int DATA_W      = 8,
   parameter int LINE_W      = 640,
   parameter int N_LINES     = 480,
   parameter int BORDER_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_valid,
   output logic                  o_req,
   output logic [3*DATA_W-1:0]   o_r0_data,
   output logic [3*DATA_W-1:0]   o_r1_data,
   output logic [3*DATA_W-1:0]   o_r2_data,
   output logic                  o_valid,
   input  logic                  i_ready,
`ifdef PS_KWIN_STATUS_EN
   output logic                  o_sof,
   output logic                  o_eol,
`endif
   output logic                  o_overflow
);
   localparam int CW  = $clog2(LINE_W);
   localparam int LNW = $clog2(N_LINES + 3);
   localparam logic [CW-1:0]     LAST_COL  = CW'(LINE_W - 1);
   localparam logic [LNW-1:0]    LAST_ROW  = LNW'(N_LINES - 1);
   localparam logic [LNW-1:0]    N_L       = LNW'(N_LINES);
   localparam logic [DATA_W-1:0] ZPIX      = '0;
   localparam bit                ZERO_FILL = (BORDER_MODE == 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WRAP} state_t;

   logic [DATA_W-1:0]   mem_q [4][LINE_W];
   state_t              state_q;
   logic [CW-1:0]       w_col_q, rd_col_q;
   logic [LNW-1:0]      w_line_q, w_line_d, r_row_q, r_row_d;
   logic [1:0]          w_sel_q, r_sel_q;
   logic                req_q, valid_q, ovf_q;
   logic [3*DATA_W-1:0] r0_q, r1_q, r2_q, r0_d, r1_d, r2_d;
   logic                accept, line_done, issue, row_end, wrap;
   logic [CW-1:0]       col_m, col_p;
   logic [1:0]          buf_t, buf_b;
   logic                is_first, is_last, zero_l, zero_r;

   // A row is readable once every line its three taps touch has been fully written.
   function automatic logic lines_ok(input logic [LNW-1:0] row, input logic [LNW-1:0] wl);
      logic [LNW-1:0] need;
      need = (row + LNW'(2) > N_L) ? N_L : row + LNW'(2);
      return wl >= need;
   endfunction

   function automatic logic [3*DATA_W-1:0] pack(input logic [DATA_W-1:0] l, m, r,
                                                 input logic zl, zr);
      return {(zr ? ZPIX : r), m, (zl ? ZPIX : l)};
   endfunction

   assign accept    = i_valid & req_q;
   assign line_done = accept && (w_col_q == LAST_COL);
   assign issue     = (state_q == S_ACTIVE) && (!valid_q || i_ready);
   assign row_end   = issue && (rd_col_q == LAST_COL);
   assign wrap      = (state_q == S_WRAP);
   assign w_line_d  = wrap ? '0 : w_line_q + LNW'(line_done);
   assign r_row_d   = wrap ? '0 : r_row_q + LNW'(row_end);

   always_comb begin
      is_first = (r_row_q == '0);
      is_last  = (r_row_q == LAST_ROW);
      col_m    = (rd_col_q == '0) ? '0 : rd_col_q - 1'b1;
      col_p    = (rd_col_q == LAST_COL) ? LAST_COL : rd_col_q + 1'b1;
      zero_l   = ZERO_FILL && (rd_col_q == '0);
      zero_r   = ZERO_FILL && (rd_col_q == LAST_COL);
      buf_t    = is_first ? r_sel_q : r_sel_q - 2'd1;
      buf_b    = is_last  ? r_sel_q : r_sel_q + 2'd1;
      r0_d = (ZERO_FILL && is_first) ? '0 :
             pack(mem_q[buf_t][col_m], mem_q[buf_t][rd_col_q], mem_q[buf_t][col_p], zero_l, zero_r);
      r1_d = pack(mem_q[r_sel_q][col_m], mem_q[r_sel_q][rd_col_q], mem_q[r_sel_q][col_p],
                  zero_l, zero_r);
      r2_d = (ZERO_FILL && is_last) ? '0 :
             pack(mem_q[buf_b][col_m], mem_q[buf_b][rd_col_q], mem_q[buf_b][col_p], zero_l, zero_r);
   end

   // NOTE: the line buffers have no reset; the counters alone decide what is readable, so stale data is never used.
   always_ff @(posedge i_clk) begin
      if (accept) mem_q[w_sel_q][w_col_q] <= i_data;
   end

   // NOTE: non-blocking assignments throughout, so every read in these blocks sees the pre-edge value.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         w_col_q  <= '0;
         w_line_q <= '0;
         w_sel_q  <= '0;
         req_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         w_line_q <= w_line_d;
         req_q    <= (w_line_d <= r_row_d + LNW'(2)) && (w_line_d < N_L);
         if (i_valid && !req_q) ovf_q <= 1'b1;
         if (wrap) begin
            w_col_q <= '0;
            w_sel_q <= '0;
         end else if (accept) begin
            w_col_q <= line_done ? '0 : w_col_q + 1'b1;
            if (line_done) w_sel_q <= w_sel_q + 2'd1;
         end
      end
   end

`ifdef PS_KWIN_STATUS_EN
   logic sof_q, eol_q;
   assign o_sof = sof_q;
   assign o_eol = eol_q;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= S_IDLE;
         rd_col_q <= '0;
         r_row_q  <= '0;
         r_sel_q  <= '0;
         valid_q  <= 1'b0;
         r0_q     <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
`ifdef PS_KWIN_STATUS_EN
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
`endif
      end else begin
         r_row_q <= r_row_d;
         case (state_q)
            S_IDLE:   if (lines_ok(r_row_q, w_line_q)) state_q <= S_ACTIVE;
            S_ACTIVE: begin
               if (row_end) begin
                  rd_col_q <= '0;
                  r_sel_q  <= r_sel_q + 2'd1;
                  if (r_row_q == LAST_ROW)                            state_q <= S_WRAP;
                  else if (!lines_ok(r_row_q + LNW'(1), w_line_q))  state_q <= S_IDLE;
               end else if (issue) begin
                  rd_col_q <= rd_col_q + 1'b1;
               end
            end
            S_WRAP: begin
               r_sel_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         if (issue) begin
            valid_q <= 1'b1;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
`ifdef PS_KWIN_STATUS_EN
            sof_q   <= is_first && (rd_col_q == '0);
            eol_q   <= (rd_col_q == LAST_COL);
`endif
         end else if (i_ready) begin
            valid_q <= 1'b0;
`ifdef PS_KWIN_STATUS_EN
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
`endif
         end
      end
   end

   assign o_req      = req_q;
   assign o_valid    = valid_q;
   assign o_overflow = ovf_q;
   assign o_r0_data  = r0_q;
   assign o_r1_data  = r1_q;
   assign o_r2_data  = r2_q;
endmodule

// File: tb/tb_ps_kernel_window.sv
// Bench for ps_kernel_window: replicate and zero-fill instances share one stimulus stream and
// are compared against a frame-array model; o_sof/o_eol are checked when PS_KWIN_STATUS_EN is defined.
module tb_ps_kernel_window;
   localparam int DW  = 8;
   localparam int LW  = 8;
   localparam int NL  = 4;
   localparam int WPF = LW * NL;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] din = '0;
   logic          vin = 1'b0;
   logic          rdy = 1'b0;

   logic          req_o  [2];
   logic          vout   [2];
   logic          ovf    [2];
   logic [23:0]   r0_o   [2];
   logic [23:0]   r1_o   [2];
   logic [23:0]   r2_o   [2];
`ifdef PS_KWIN_STATUS_EN
   logic          sof_o  [2];
   logic          eol_o  [2];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ps_kernel_window #(.DATA_W(DW), .LINE_W(LW), .N_LINES(NL), .BORDER_MODE(g)) dut (
         .i_clk(clk), .i_rstn(rstn), .i_data(din), .i_valid(vin), .o_req(req_o[g]),
         .o_r0_data(r0_o[g]), .o_r1_data(r1_o[g]), .o_r2_data(r2_o[g]),
         .o_valid(vout[g]), .i_ready(rdy),
`ifdef PS_KWIN_STATUS_EN
         .o_sof(sof_o[g]), .o_eol(eol_o[g]),
`endif
         .o_overflow(ovf[g]));
   end

   typedef struct {
      int          mode;
      int          row;
      int          col;
      logic [23:0] r0, r1, r2;
   } vec_t;
   vec_t vecs [7];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: accepted pixels land in a per-frame image; windows are derived from it.
   logic [DW-1:0] img [2][NL][LW];
   logic [23:0]   cap [2][NL][LW][3];
   int  wr_idx = 0, n_win = 0;
   int  valid_pct = 0, ready_pct = 100;
   bit  gate_req = 1, rand_data = 0, capture = 0, exp_ovf = 0, saw_req_low = 0, held = 0;
   int  stall_target = -1, stall_left = 0, first_valid_pix = -1;
   logic [23:0] hr0 [2], hr1 [2], hr2 [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] tap(int f, int ln, int c, int mode);
      if (ln < 0 || ln >= NL || c < 0 || c >= LW) begin
         if (mode == 1) return '0;
         ln = (ln < 0) ? 0 : ((ln >= NL) ? NL - 1 : ln);
         c  = (c < 0) ? 0 : ((c >= LW) ? LW - 1 : c);
      end
      return img[f][ln][c];
   endfunction

   function automatic logic [23:0] exp_row(int f, int ln, int c, int mode);
      return {tap(f, ln, c + 1, mode), tap(f, ln, c, mode), tap(f, ln, c - 1, mode)};
   endfunction

   task automatic cycle();
      int f, r, c, line, col;
      @(negedge clk);
      if (held) begin
         check("hold_valid", vout[0], 1'b1);
         for (int d = 0; d < 2; d++) begin
            check("hold_r0", r0_o[d], hr0[d]);
            check("hold_r1", r1_o[d], hr1[d]);
            check("hold_r2", r2_o[d], hr2[d]);
         end
      end
      if (stall_target >= 0 && vout[0] && n_win == stall_target) begin
         stall_left   = 5;
         stall_target = -1;
      end
      if (stall_left > 0) begin
         rdy = 1'b0;
         stall_left--;
      end else begin
         rdy = ($urandom_range(99) < ready_pct);
      end
      line = (wr_idx % WPF) / LW;
      col  = wr_idx % LW;
      vin  = ($urandom_range(99) < valid_pct) && (!gate_req || req_o[0]);
      din  = rand_data ? DW'($urandom) : DW'(16 * line + col);
      if (!req_o[0]) saw_req_low = 1;
      if (vout[0] && first_valid_pix < 0) first_valid_pix = wr_idx;
      if (vin && !req_o[0]) exp_ovf = 1;
      if (vin && req_o[0]) begin
         img[(wr_idx / WPF) % 2][line][col] = din;
         wr_idx++;
      end
      if (vout[0] && rdy) begin
         f = (n_win / WPF) % 2;
         r = (n_win % WPF) / LW;
         c = n_win % LW;
         check("valid_zero_inst", vout[1], 1'b1);
         for (int d = 0; d < 2; d++) begin
            check("win_r0", r0_o[d], exp_row(f, r - 1, c, d));
            check("win_r1", r1_o[d], exp_row(f, r, c, d));
            check("win_r2", r2_o[d], exp_row(f, r + 1, c, d));
`ifdef PS_KWIN_STATUS_EN
            check("sof", sof_o[d], (r == 0 && c == 0));
            check("eol", eol_o[d], (c == LW - 1));
`endif
            if (capture) begin
               cap[d][r][c][0] = r0_o[d];
               cap[d][r][c][1] = r1_o[d];
               cap[d][r][c][2] = r2_o[d];
            end
         end
         n_win++;
      end
      held = vout[0] && !rdy;
      for (int d = 0; d < 2; d++) begin
         hr0[d] = r0_o[d];
         hr1[d] = r1_o[d];
         hr2[d] = r2_o[d];
      end
   endtask

   task automatic run_until(input int target, input int budget);
      int n = 0;
      while (n_win < target && n < budget) begin
         cycle();
         n++;
      end
      check("windows_within_budget", (n_win >= target), 1'b1);
   endtask

   task automatic idle_and_count(input int expect_win);
      valid_pct = 0;
      repeat (30) cycle();
      check("window_count", n_win, expect_win);
   endtask

   task automatic check_zero();
      for (int d = 0; d < 2; d++) begin
         check("rst_req", req_o[d], 1'b0);
         check("rst_valid", vout[d], 1'b0);
         check("rst_overflow", ovf[d], 1'b0);
         check("rst_r0", r0_o[d], 24'h0);
         check("rst_r1", r1_o[d], 24'h0);
         check("rst_r2", r2_o[d], 24'h0);
`ifdef PS_KWIN_STATUS_EN
         check("rst_sof", sof_o[d], 1'b0);
         check("rst_eol", eol_o[d], 1'b0);
`endif
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rstn = 1'b0;
      vin  = 1'b0;
      rdy  = 1'b0;
      @(negedge clk);
      check_zero();
      rstn    = 1'b1;
      wr_idx  = 0;
      n_win   = 0;
      exp_ovf = 0;
      held    = 0;
   endtask

   task automatic check_table();
      foreach (vecs[i]) begin
         check("vec_r0", cap[vecs[i].mode][vecs[i].row][vecs[i].col][0], vecs[i].r0);
         check("vec_r1", cap[vecs[i].mode][vecs[i].row][vecs[i].col][1], vecs[i].r1);
         check("vec_r2", cap[vecs[i].mode][vecs[i].row][vecs[i].col][2], vecs[i].r2);
      end
   endtask

   // Directed frame with pixel = 16*line + col, continuous flow gated by o_req.
   task automatic directed_frame();
      gate_req = 1; valid_pct = 100; ready_pct = 100; rand_data = 0; capture = 1;
      saw_req_low = 0; first_valid_pix = -1;
      run_until(n_win + WPF, 500);
      capture = 0;
      idle_and_count(WPF);
      check("first_valid_after_line1", (first_valid_pix >= 2 * LW), 1'b1);
      check("req_dropped", saw_req_low, 1'b1);
      check("overflow_clear0", ovf[0], exp_ovf);
      check("overflow_clear1", ovf[1], exp_ovf);
      check_table();
   endtask

   initial begin
      int base;
      vecs[0] = '{0, 0, 0, 24'h010000, 24'h010000, 24'h111010};
      vecs[1] = '{1, 0, 0, 24'h000000, 24'h010000, 24'h111000};
      vecs[2] = '{0, 3, 7, 24'h272726, 24'h373736, 24'h373736};
      vecs[3] = '{1, 3, 7, 24'h002726, 24'h003736, 24'h000000};
      vecs[4] = '{0, 1, 3, 24'h040302, 24'h141312, 24'h242322};
      vecs[5] = '{1, 2, 0, 24'h111000, 24'h212000, 24'h313000};
      vecs[6] = '{0, 2, 7, 24'h171716, 24'h272726, 24'h373736};

      repeat (3) @(negedge clk);
      check_zero();
      rstn = 1'b1;

      directed_frame();

      base = n_win;
      stall_target = base + LW + 3;
      valid_pct = 100; ready_pct = 100;
      run_until(base + WPF, 500);
      idle_and_count(base + WPF);
      check("stall_applied", stall_target, -1);

      base = n_win;
      rand_data = 1; valid_pct = 70; ready_pct = 60;
      run_until(base + 3 * WPF, 3000);
      idle_and_count(base + 3 * WPF);

      base = n_win;
      rand_data = 0; gate_req = 0; valid_pct = 60; ready_pct = 80;
      run_until(base + WPF, 1000);
      idle_and_count(base + WPF);
      check("overflow_sticky0", ovf[0], exp_ovf);
      check("overflow_sticky1", ovf[1], exp_ovf);

      gate_req = 1; valid_pct = 100; ready_pct = 100;
      run_until(n_win + 2 * LW, 500);
      reset_pulse();
      directed_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
